// File: rtl/qc_ldpc_enc_ctrl_param.sv
// ---------------------------------------------------------------------------
// qc_ldpc_enc_ctrl_param
//
// Control path for a quasi-cyclic LDPC encoder built around an SRAA
// (shift-register-adder-accumulator) datapath. The controller owns the
// bit-within-block and block counters and sequences two phases:
//
//   1. info accumulate : INFO_BLOCKS * CIRC_SIZE message bits are accepted
//                        over a valid/ready handshake; each accepted bit steps
//                        the SRAA once. A one-cycle NEXT_BLK gap between info
//                        blocks reloads the shift register with the next
//                        generator row.
//   2. parity unload   : the accumulator is transferred to the parity output
//                        register, then (TOTAL_BLOCKS-INFO_BLOCKS) * CIRC_SIZE
//                        parity bits are shifted out under downstream
//                        back-pressure, with no bubble between parity blocks.
//
// A one-cycle done pulse marks codeword completion, after which the FSM
// returns to IDLE. Synchronous reset aborts any codeword in flight.
//
// Ports
//   clk         : clock, all state on the rising edge
//   reset       : synchronous active-high reset / abort
//   start       : begin one codeword (only looked at in IDLE)
//   msg_valid   : message bit present at datapath input
//   msg_ready   : controller accepts a message bit (ACCUM only)
//   par_ready   : downstream accepts a parity bit
//   par_valid   : parity bit valid at datapath output (PAR_OUT only)
//   clear_acc   : clear SRAA accumulator
//   load_shift  : load SRAA shift register with current block's generator row
//   acc_en      : accumulate/shift one step (msg_valid & msg_ready)
//   load_par    : move accumulator into parity output register
//   par_shift   : shift parity register one bit (par_valid & par_ready)
//   bit_idx     : bit counter within current block
//   blk_idx     : current block index
//   busy        : high in every state except IDLE
//   done        : one-cycle pulse at codeword completion
// ---------------------------------------------------------------------------
module qc_ldpc_enc_ctrl_param #(
  parameter int CIRC_SIZE    = 87,
  parameter int INFO_BLOCKS  = 24,
  parameter int TOTAL_BLOCKS = 41,
  localparam int BIT_W = $clog2(CIRC_SIZE),
  localparam int BLK_W = $clog2(TOTAL_BLOCKS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic             par_ready,
  output logic             par_valid,
  output logic             clear_acc,
  output logic             load_shift,
  output logic             acc_en,
  output logic             load_par,
  output logic             par_shift,
  output logic [BIT_W-1:0] bit_idx,
  output logic [BLK_W-1:0] blk_idx,
  output logic             busy,
  output logic             done
);

  // Parameter sanity: a bad configuration must fail at elaboration, not
  // produce a silently broken controller.
  if (TOTAL_BLOCKS <= INFO_BLOCKS || CIRC_SIZE < 2 || INFO_BLOCKS < 1) begin : g_param_check
    $error("qc_ldpc_enc_ctrl_param: illegal parameters (need CIRC_SIZE>=2, INFO_BLOCKS>=1, TOTAL_BLOCKS>INFO_BLOCKS)");
  end

  localparam logic [BIT_W-1:0] BIT_LAST       = BIT_W'(CIRC_SIZE - 1);
  localparam logic [BLK_W-1:0] BLK_INFO_LAST  = BLK_W'(INFO_BLOCKS - 1);
  localparam logic [BLK_W-1:0] BLK_PAR_FIRST  = BLK_W'(INFO_BLOCKS);
  localparam logic [BLK_W-1:0] BLK_TOTAL_LAST = BLK_W'(TOTAL_BLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_ACCUM    = 3'd2,
    S_NEXT_BLK = 3'd3,
    S_PAR_LOAD = 3'd4,
    S_PAR_OUT  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic [BLK_W-1:0] blk_idx_q, blk_idx_d;

  logic bit_last;
  assign bit_last = (bit_idx_q == BIT_LAST);

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_idx_q <= '0;
      blk_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      blk_idx_q <= blk_idx_d;
    end
  end

  // Next-state, counter update and strobe decode. Strobes are decoded from
  // the current state; the handshake strobes additionally qualify with the
  // partner's valid/ready so that a stalled cycle changes nothing.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    blk_idx_d  = blk_idx_q;
    msg_ready  = 1'b0;
    par_valid  = 1'b0;
    clear_acc  = 1'b0;
    load_shift = 1'b0;
    acc_en     = 1'b0;
    load_par   = 1'b0;
    par_shift  = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
        end
      end

      S_INIT: begin
        clear_acc  = 1'b1;
        load_shift = 1'b1;
        bit_idx_d  = '0;
        blk_idx_d  = '0;
        state_d    = S_ACCUM;
      end

      S_ACCUM: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          acc_en = 1'b1;
          if (bit_last) begin
            bit_idx_d = '0;
            // Block index is advanced in NEXT_BLK, or jumped to the first
            // parity block in PAR_LOAD, so it stays put here.
            if (blk_idx_q == BLK_INFO_LAST) begin
              state_d = S_PAR_LOAD;
            end else begin
              state_d = S_NEXT_BLK;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end

      S_NEXT_BLK: begin
        blk_idx_d  = blk_idx_q + 1'b1;
        load_shift = 1'b1;
        state_d    = S_ACCUM;
      end

      S_PAR_LOAD: begin
        load_par  = 1'b1;
        blk_idx_d = BLK_PAR_FIRST;
        bit_idx_d = '0;
        state_d   = S_PAR_OUT;
      end

      S_PAR_OUT: begin
        par_valid = 1'b1;
        if (par_ready) begin
          par_shift = 1'b1;
          if (bit_last) begin
            bit_idx_d = '0;
            if (blk_idx_q == BLK_TOTAL_LAST) begin
              // Final parity bit: leave blk_idx on the last block rather
              // than stepping past TOTAL_BLOCKS-1.
              state_d = S_DONE;
            end else begin
              // Reload in the same cycle so parity blocks stream without
              // a gap cycle.
              blk_idx_d  = blk_idx_q + 1'b1;
              load_shift = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        // start is deliberately not looked at here; a new codeword always
        // passes through IDLE.
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign bit_idx = bit_idx_q;
  assign blk_idx = blk_idx_q;

endmodule

// File: tb/tb_qc_ldpc_enc_ctrl_param.sv
// ---------------------------------------------------------------------------
// Directed bench for qc_ldpc_enc_ctrl_param. One instance uses the default
// parameters (87/24/41), a second a tiny 4/2/3 configuration whose state
// sequence is spelled out cycle by cycle. Inputs change on the falling edge;
// outputs are sampled 1 time unit later.
// Cycle numbering: cycle 0 is the cycle in which start is first sampled.
// ---------------------------------------------------------------------------
module tb_qc_ldpc_enc_ctrl_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic       start_a, msg_valid_a, par_ready_a;
  logic       msg_ready_a, par_valid_a, clear_acc_a, load_shift_a, acc_en_a;
  logic       load_par_a, par_shift_a, busy_a, done_a;
  logic [6:0] bit_idx_a;
  logic [5:0] blk_idx_a;

  // Instance B: CIRC_SIZE=4, INFO_BLOCKS=2, TOTAL_BLOCKS=3
  logic       start_b, msg_valid_b, par_ready_b;
  logic       msg_ready_b, par_valid_b, clear_acc_b, load_shift_b, acc_en_b;
  logic       load_par_b, par_shift_b, busy_b, done_b;
  logic [1:0] bit_idx_b;
  logic [1:0] blk_idx_b;

  logic [8:0] outs_a, outs_b;
  assign outs_a = {msg_ready_a, par_valid_a, clear_acc_a, load_shift_a, acc_en_a,
                   load_par_a, par_shift_a, busy_a, done_a};
  assign outs_b = {msg_ready_b, par_valid_b, clear_acc_b, load_shift_b, acc_en_b,
                   load_par_b, par_shift_b, busy_b, done_b};

  qc_ldpc_enc_ctrl_param dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .msg_valid(msg_valid_a), .msg_ready(msg_ready_a),
    .par_ready(par_ready_a), .par_valid(par_valid_a),
    .clear_acc(clear_acc_a), .load_shift(load_shift_a), .acc_en(acc_en_a),
    .load_par(load_par_a), .par_shift(par_shift_a),
    .bit_idx(bit_idx_a), .blk_idx(blk_idx_a), .busy(busy_a), .done(done_a)
  );

  qc_ldpc_enc_ctrl_param #(.CIRC_SIZE(4), .INFO_BLOCKS(2), .TOTAL_BLOCKS(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .msg_valid(msg_valid_b), .msg_ready(msg_ready_b),
    .par_ready(par_ready_b), .par_valid(par_valid_b),
    .clear_acc(clear_acc_b), .load_shift(load_shift_b), .acc_en(acc_en_b),
    .load_par(load_par_b), .par_shift(par_shift_b),
    .bit_idx(bit_idx_b), .blk_idx(blk_idx_b), .busy(busy_b), .done(done_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Results of the last run_a call.
  int r_done1, r_done2, r_init2, r_acc, r_par, r_ldinfo, r_stall, r_ndone;
  int r_unstable, r_load_par, r_first_par_blk, r_bnd_hold, r_end_ok;

  // Drive instance A through n_cw codewords. rnd: 50% stalls on both sides.
  // hold_start: keep start high until n_cw done pulses were seen.
  // boundary: drop msg_valid for 3 cycles at the last bit of the last info block.
  task automatic run_a(input bit rnd, input bit hold_start, input bit boundary, input int n_cw);
    int         cyc, bstall, after;
    bit         pstall;
    logic [6:0] pbit;
    logic [5:0] pblk;
    r_done1 = -1; r_done2 = -1; r_init2 = -1; r_acc = 0; r_par = 0; r_ldinfo = 0;
    r_stall = 0; r_ndone = 0; r_unstable = 0; r_load_par = -1; r_first_par_blk = -1;
    r_bnd_hold = 0;
    cyc = 0; bstall = 0; after = -1; pstall = 1'b0; pbit = '0; pblk = '0;
    while (cyc < 20000 && after != 0) begin
      @(negedge clk);
      start_a     = (cyc == 0) || (hold_start && r_ndone < n_cw);
      msg_valid_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      par_ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (boundary && msg_ready_a && bit_idx_a == 7'd86 && blk_idx_a == 6'd23 && bstall < 3) begin
        msg_valid_a = 1'b0;
        bstall++;
      end
      #1;
      if (pstall && (bit_idx_a !== pbit || blk_idx_a !== pblk)) r_unstable++;
      pstall = (msg_ready_a && !msg_valid_a) || (par_valid_a && !par_ready_a);
      pbit = bit_idx_a;
      pblk = blk_idx_a;
      if (pstall) r_stall++;
      if (acc_en_a) r_acc++;
      if (par_shift_a) r_par++;
      if (load_shift_a && !par_valid_a) r_ldinfo++;
      if (msg_ready_a && bit_idx_a == 7'd86 && blk_idx_a == 6'd23) r_bnd_hold++;
      if (load_par_a && r_load_par < 0) r_load_par = cyc;
      if (par_valid_a && r_first_par_blk < 0) r_first_par_blk = int'(blk_idx_a);
      if (clear_acc_a && r_ndone == 1 && r_init2 < 0) r_init2 = cyc;
      if (done_a) begin
        r_ndone++;
        if (r_ndone == 1) r_done1 = cyc;
        if (r_ndone == 2) r_done2 = cyc;
        if (r_ndone == n_cw) after = 5;
      end
      if (after > 0) after--;
      cyc++;
    end
    r_end_ok = (after == 0) ? 1 : 0;
    @(negedge clk);
    start_a = 1'b0; msg_valid_a = 1'b0; par_ready_a = 1'b0;
  endtask

  // Decode instance B's state from its strobes:
  // 0 IDLE, 1 INIT, 2 ACCUM, 3 NEXT_BLK, 4 PAR_LOAD, 5 PAR_OUT, 6 DONE, 7 unknown
  function automatic int st_b();
    if (done_b)            return 6;
    else if (par_valid_b)  return 5;
    else if (load_par_b)   return 4;
    else if (msg_ready_b)  return 2;
    else if (clear_acc_b)  return 1;
    else if (load_shift_b) return 3;
    else if (busy_b)       return 7;
    else                   return 0;
  endfunction

  int  exp_seq [18] = '{0, 1, 2, 2, 2, 2, 3, 2, 2, 2, 2, 4, 5, 5, 5, 5, 6, 0};
  bit  found;

  initial begin
    reset = 1'b1;
    start_a = 1'b0; msg_valid_a = 1'b0; par_ready_a = 1'b0;
    start_b = 1'b0; msg_valid_b = 1'b0; par_ready_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outs_a", 32'(outs_a), 0);
    check("reset_bit_a", 32'(bit_idx_a), 0);
    check("reset_blk_a", 32'(blk_idx_a), 0);
    check("reset_outs_b", 32'(outs_b), 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: default params, no stalls
    run_a(1'b0, 1'b0, 1'b0, 1);
    check("t1_end", 32'(r_end_ok), 1);
    check("t1_done_cycle", 32'(r_done1), 3593);
    check("t1_done_pulses", 32'(r_ndone), 1);
    check("t1_acc_en", 32'(r_acc), 2088);
    check("t1_par_shift", 32'(r_par), 1479);
    check("t1_load_shift_info", 32'(r_ldinfo), 24);
    check("t1_load_par_cycle", 32'(r_load_par), 2113);
    check("t1_first_par_blk", 32'(r_first_par_blk), 24);
    $display("t1 default no-stall: done@%0d acc=%0d par=%0d", r_done1, r_acc, r_par);

    // 2: tiny configuration, cycle-exact state sequence
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      start_b = (c == 0);
      msg_valid_b = 1'b1;
      par_ready_b = 1'b1;
      #1;
      check($sformatf("t2_state_c%0d", c), 32'(st_b()), 32'(exp_seq[c]));
      if (c == 6)  check("t2_blk_next", 32'(blk_idx_b), 0);
      if (c == 7)  check("t2_blk_acc1", 32'(blk_idx_b), 1);
      if (c == 12) check("t2_blk_par", 32'(blk_idx_b), 2);
      if (c == 15) check("t2_bit_par_last", 32'(bit_idx_b), 3);
    end
    start_b = 1'b0; msg_valid_b = 1'b0; par_ready_b = 1'b0;
    $display("t2 small params: state sequence checked");

    // 3: random 50% stalls on both handshakes
    run_a(1'b1, 1'b0, 1'b0, 1);
    check("t3_end", 32'(r_end_ok), 1);
    check("t3_acc_en", 32'(r_acc), 2088);
    check("t3_par_shift", 32'(r_par), 1479);
    check("t3_done_cycle", 32'(r_done1), 32'(3593 + r_stall));
    check("t3_idx_stable", 32'(r_unstable), 0);
    check("t3_done_pulses", 32'(r_ndone), 1);
    $display("t3 random stalls: stalls=%0d done@%0d", r_stall, r_done1);

    // 4: abort in ACCUM at block 5 bit 30
    @(negedge clk);
    start_a = 1'b1; msg_valid_a = 1'b1; par_ready_a = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      #1;
      if (msg_ready_a && blk_idx_a == 6'd5 && bit_idx_a == 7'd30) found = 1'b1;
    end
    check("t4_reached_blk5_bit30", 32'(found), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t4_abort_outs", 32'(outs_a), 0);
    check("t4_abort_bit", 32'(bit_idx_a), 0);
    check("t4_abort_blk", 32'(blk_idx_a), 0);
    @(negedge clk);
    reset = 1'b0; msg_valid_a = 1'b0; par_ready_a = 1'b0;
    #1;
    check("t4_idle_after_abort", 32'(busy_a), 0);
    run_a(1'b0, 1'b0, 1'b0, 1);
    check("t4_end", 32'(r_end_ok), 1);
    check("t4_rerun_done_cycle", 32'(r_done1), 3593);
    $display("t4 abort + rerun: done@%0d", r_done1);

    // 5: start held high -> back-to-back codewords with one IDLE cycle
    run_a(1'b0, 1'b1, 1'b0, 2);
    check("t5_end", 32'(r_end_ok), 1);
    check("t5_done1_cycle", 32'(r_done1), 3593);
    check("t5_init2_cycle", 32'(r_init2), 3595);
    check("t5_done2_cycle", 32'(r_done2), 7187);
    check("t5_done_pulses", 32'(r_ndone), 2);
    $display("t5 back-to-back: done1@%0d init2@%0d done2@%0d", r_done1, r_init2, r_done2);

    // 6: msg_valid low at the last bit of the last info block
    run_a(1'b0, 1'b0, 1'b1, 1);
    check("t6_end", 32'(r_end_ok), 1);
    check("t6_boundary_hold", 32'(r_bnd_hold), 4);
    check("t6_load_par_cycle", 32'(r_load_par), 2116);
    check("t6_first_par_blk", 32'(r_first_par_blk), 24);
    check("t6_idx_stable", 32'(r_unstable), 0);
    check("t6_done_cycle", 32'(r_done1), 3596);
    $display("t6 boundary stall: load_par@%0d done@%0d", r_load_par, r_done1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
